// File: rtl/hist_eq_pkg.sv
// Shared definitions for the histogram-equalisation parameter controller:
// FSM states, register map and the power-up parameter set.
package hist_eq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ARMED = 2'd2
    } hist_eq_state_e;

    localparam logic [1:0] ADDR_CONTRAST = 2'd0;
    localparam logic [1:0] ADDR_UPPER    = 2'd1;
    localparam logic [1:0] ADDR_LOWER    = 2'd2;
    localparam logic [1:0] ADDR_CTRL     = 2'd3;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_ERR_CLR_BIT = 1;

    localparam int unsigned BOUND_WIDTH = 10;

    localparam int unsigned             RST_CONTRAST = 128;
    localparam logic [BOUND_WIDTH-1:0]  RST_UPPER    = 10'd717;
    localparam logic [BOUND_WIDTH-1:0]  RST_LOWER    = 10'd205;
    localparam logic                    RST_THR_EN   = 1'b1;

    // A bound pair is only usable if it describes a non-empty window.
    function automatic logic bounds_valid(input logic [BOUND_WIDTH-1:0] lower,
                                          input logic [BOUND_WIDTH-1:0] upper);
        return lower < upper;
    endfunction

endpackage

// File: rtl/hist_eq_param_ctrl.sv
// Holds a shadow parameter set for the hist_eq datapath and swaps it into the
// active set only at a frame start, so parameters never change mid-frame.
module hist_eq_param_ctrl
    import hist_eq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_aresetn,
    input  logic                   cfg_wr_valid,
    output logic                   cfg_wr_ready,
    input  logic [1:0]             cfg_wr_addr,
    input  logic [15:0]            cfg_wr_data,
    input  logic                   cfg_commit,
    input  logic                   mon_tvalid,
    input  logic                   mon_tuser,
    output logic [DATA_WIDTH-1:0]  contrast_threshold_param,
    output logic [9:0]             upper_bound_param,
    output logic [9:0]             lower_bound_param,
    output logic                   thresholding_en,
    output logic                   cfg_pending,
    output logic                   cfg_applied,
    output logic                   cfg_err,
    output logic [FCNT_WIDTH-1:0]  frame_cnt
);

    localparam logic [DATA_WIDTH-1:0] RST_CONTRAST_W = DATA_WIDTH'(RST_CONTRAST);

    hist_eq_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0]  sh_contrast_q, sh_contrast_d;
    logic [9:0]             sh_upper_q, sh_upper_d;
    logic [9:0]             sh_lower_q, sh_lower_d;
    logic                   sh_thr_en_q, sh_thr_en_d;

    logic [DATA_WIDTH-1:0]  act_contrast_q, act_contrast_d;
    logic [9:0]             act_upper_q, act_upper_d;
    logic [9:0]             act_lower_q, act_lower_d;
    logic                   act_thr_en_q, act_thr_en_d;

    logic                   cfg_pending_q, cfg_pending_d;
    logic                   cfg_applied_q, cfg_applied_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [FCNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;

    logic sof;
    logic wr_fire;
    logic commit_ok;
    logic apply;
    logic err_set;
    logic err_clr;
    logic unused_wr_bits;

    assign sof       = mon_tvalid & mon_tuser;
    assign wr_fire   = cfg_wr_valid & cfg_wr_ready;
    assign commit_ok = bounds_valid(sh_lower_q, sh_upper_q);

    // Upper data bits carry nothing for any register in the map.
    assign unused_wr_bits = ^cfg_wr_data[15:10];

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_commit) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = commit_ok ? ST_ARMED : ST_IDLE;
            end
            ST_ARMED: begin
                if (sof) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A commit in the same cycle as a write takes priority and stalls the write.
    always_comb begin
        cfg_wr_ready  = (state_q == ST_IDLE) & ~cfg_commit;
        apply         = (state_q == ST_ARMED) & sof;
        err_set       = (state_q == ST_CHECK) & ~commit_ok;
        cfg_applied_d = apply;
        cfg_pending_d = (state_d == ST_ARMED);
    end

    always_comb begin
        sh_contrast_d = sh_contrast_q;
        sh_upper_d    = sh_upper_q;
        sh_lower_d    = sh_lower_q;
        sh_thr_en_d   = sh_thr_en_q;
        err_clr       = 1'b0;
        if (wr_fire) begin
            unique case (cfg_wr_addr)
                ADDR_CONTRAST: sh_contrast_d = cfg_wr_data[DATA_WIDTH-1:0];
                ADDR_UPPER:    sh_upper_d    = cfg_wr_data[9:0];
                ADDR_LOWER:    sh_lower_d    = cfg_wr_data[9:0];
                ADDR_CTRL: begin
                    sh_thr_en_d = cfg_wr_data[CTRL_EN_BIT];
                    err_clr     = cfg_wr_data[CTRL_ERR_CLR_BIT];
                end
                default: begin
                    sh_thr_en_d = sh_thr_en_q;
                end
            endcase
        end
    end

    always_comb begin
        act_contrast_d = act_contrast_q;
        act_upper_d    = act_upper_q;
        act_lower_d    = act_lower_q;
        act_thr_en_d   = act_thr_en_q;
        if (apply) begin
            act_contrast_d = sh_contrast_q;
            act_upper_d    = sh_upper_q;
            act_lower_d    = sh_lower_q;
            act_thr_en_d   = sh_thr_en_q;
        end
    end

    // A rejected commit beats a simultaneous write-one-to-clear.
    always_comb begin
        cfg_err_d = cfg_err_q;
        if (err_clr) begin
            cfg_err_d = 1'b0;
        end
        if (err_set) begin
            cfg_err_d = 1'b1;
        end
        frame_cnt_d = frame_cnt_q;
        if (sof) begin
            frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            sh_contrast_q  <= RST_CONTRAST_W;
            sh_upper_q     <= RST_UPPER;
            sh_lower_q     <= RST_LOWER;
            sh_thr_en_q    <= RST_THR_EN;
            act_contrast_q <= RST_CONTRAST_W;
            act_upper_q    <= RST_UPPER;
            act_lower_q    <= RST_LOWER;
            act_thr_en_q   <= RST_THR_EN;
            cfg_pending_q  <= 1'b0;
            cfg_applied_q  <= 1'b0;
            cfg_err_q      <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            sh_contrast_q  <= sh_contrast_d;
            sh_upper_q     <= sh_upper_d;
            sh_lower_q     <= sh_lower_d;
            sh_thr_en_q    <= sh_thr_en_d;
            act_contrast_q <= act_contrast_d;
            act_upper_q    <= act_upper_d;
            act_lower_q    <= act_lower_d;
            act_thr_en_q   <= act_thr_en_d;
            cfg_pending_q  <= cfg_pending_d;
            cfg_applied_q  <= cfg_applied_d;
            cfg_err_q      <= cfg_err_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign contrast_threshold_param = act_contrast_q;
    assign upper_bound_param        = act_upper_q;
    assign lower_bound_param        = act_lower_q;
    assign thresholding_en          = act_thr_en_q;
    assign cfg_pending              = cfg_pending_q;
    assign cfg_applied              = cfg_applied_q;
    assign cfg_err                  = cfg_err_q;
    assign frame_cnt                = frame_cnt_q;

endmodule

// File: tb/tb_hist_eq_param_ctrl.sv
// Scoreboard bench for hist_eq_param_ctrl: a reference model predicts the
// registered outputs after every clock; a monitor pops and compares them.
module tb_hist_eq_param_ctrl;

    localparam int DW = 8;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cfg_wr_valid;
    logic          cfg_wr_ready;
    logic [1:0]    cfg_wr_addr;
    logic [15:0]   cfg_wr_data;
    logic          cfg_commit;
    logic          mon_tvalid;
    logic          mon_tuser;
    logic [DW-1:0] contrast_threshold_param;
    logic [9:0]    upper_bound_param;
    logic [9:0]    lower_bound_param;
    logic          thresholding_en;
    logic          cfg_pending;
    logic          cfg_applied;
    logic          cfg_err;
    logic [FW-1:0] frame_cnt;

    always #5 clk = ~clk;

    hist_eq_param_ctrl #(.DATA_WIDTH(DW), .FCNT_WIDTH(FW)) dut (
        .i_sys_clk                (clk),
        .i_sys_aresetn            (resetn),
        .cfg_wr_valid             (cfg_wr_valid),
        .cfg_wr_ready             (cfg_wr_ready),
        .cfg_wr_addr              (cfg_wr_addr),
        .cfg_wr_data              (cfg_wr_data),
        .cfg_commit               (cfg_commit),
        .mon_tvalid               (mon_tvalid),
        .mon_tuser                (mon_tuser),
        .contrast_threshold_param (contrast_threshold_param),
        .upper_bound_param        (upper_bound_param),
        .lower_bound_param        (lower_bound_param),
        .thresholding_en          (thresholding_en),
        .cfg_pending              (cfg_pending),
        .cfg_applied              (cfg_applied),
        .cfg_err                  (cfg_err),
        .frame_cnt                (frame_cnt)
    );

    typedef struct {
        int contrast;
        int upper;
        int lower;
        int en;
        int pending;
        int applied;
        int err;
        int fcnt;
    } snap_t;

    snap_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: parameter sets as arrays {contrast, upper, lower, en};
    // commit_age counts how far a commit has progressed (0 none, 1 judged next, 2 waiting for SOF).
    int sh[4];
    int act[4];
    int commit_age;
    int m_err;
    int m_fcnt;

    function automatic void model_reset();
        sh[0] = 128; sh[1] = 717; sh[2] = 205; sh[3] = 1;
        act = sh;
        commit_age = 0;
        m_err = 0;
        m_fcnt = 0;
    endfunction

    function automatic void model_step(input bit wv, input bit [1:0] addr, input bit [15:0] data,
                                       input bit commit, input bit tv, input bit tu);
        snap_t s;
        bit sof;
        bit ready;
        int applied;
        sof = tv && tu;
        ready = (commit_age == 0) && !commit;
        applied = 0;
        if (wv && ready) begin
            case (addr)
                2'd0: sh[0] = int'(data) % 256;
                2'd1: sh[1] = int'(data) % 1024;
                2'd2: sh[2] = int'(data) % 1024;
                default: begin
                    sh[3] = int'(data) % 2;
                    if (((int'(data) / 2) % 2) == 1) m_err = 0;
                end
            endcase
        end
        if (commit_age == 0) begin
            if (commit) commit_age = 1;
        end else if (commit_age == 1) begin
            if (sh[2] < sh[1]) commit_age = 2;
            else begin
                m_err = 1;
                commit_age = 0;
            end
        end else if (sof) begin
            act = sh;
            applied = 1;
            commit_age = 0;
        end
        if (sof) m_fcnt = (m_fcnt + 1) % (1 << FW);
        s.contrast = act[0];
        s.upper    = act[1];
        s.lower    = act[2];
        s.en       = act[3];
        s.pending  = (commit_age == 2) ? 1 : 0;
        s.applied  = applied;
        s.err      = m_err;
        s.fcnt     = m_fcnt;
        exp_q.push_back(s);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at a falling edge; drives one clock's worth of inputs and returns at the next falling edge.
    task automatic applyStimulus(input bit wv, input bit [1:0] addr, input bit [15:0] data,
                                 input bit commit, input bit tv, input bit tu);
        cfg_wr_valid = wv;
        cfg_wr_addr  = addr;
        cfg_wr_data  = data;
        cfg_commit   = commit;
        mon_tvalid   = tv;
        mon_tuser    = tu;
        #1;
        checkOutput("cfg_wr_ready", int'(cfg_wr_ready), ((commit_age == 0) && !commit) ? 1 : 0);
        model_step(wv, addr, data, commit, tv, tu);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input bit [1:0] addr, input bit [15:0] data);
        applyStimulus(1'b1, addr, data, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic commitReq();
        applyStimulus(1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic sofBeat();
        applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic doReset();
        #2;
        resetn       = 1'b0;
        cfg_wr_valid = 1'b0;
        cfg_wr_addr  = 2'd0;
        cfg_wr_data  = 16'd0;
        cfg_commit   = 1'b0;
        mon_tvalid   = 1'b0;
        mon_tuser    = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (resetn && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("contrast", int'(contrast_threshold_param), e.contrast);
                checkOutput("upper",    int'(upper_bound_param),        e.upper);
                checkOutput("lower",    int'(lower_bound_param),        e.lower);
                checkOutput("thr_en",   int'(thresholding_en),          e.en);
                checkOutput("pending",  int'(cfg_pending),              e.pending);
                checkOutput("applied",  int'(cfg_applied),              e.applied);
                checkOutput("cfg_err",  int'(cfg_err),                  e.err);
                checkOutput("frame_cnt", int'(frame_cnt),               e.fcnt);
            end
        end
    end

    initial begin
        bit        wv, cm, tv, tu;
        bit [1:0]  addr;
        bit [15:0] data;

        resetn = 1'b0;
        @(negedge clk);
        doReset();
        $display("[TB] reset defaults");
        idle(2);

        $display("[TB] frame-aligned apply");
        wr(2'd1, 16'd800);
        wr(2'd2, 16'd100);
        commitReq();
        idle(4);
        sofBeat();
        idle(2);

        $display("[TB] invalid commit and error clear");
        wr(2'd2, 16'd900);
        commitReq();
        idle(3);
        wr(2'd3, 16'h0003);
        idle(2);

        $display("[TB] write blocking during commit and armed");
        wr(2'd2, 16'd50);
        applyStimulus(1'b1, 2'd1, 16'd600, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd1, 16'd600, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 16'd600, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'd1, 16'd600, 1'b0, 1'b0, 1'b0);
        idle(1);
        commitReq();
        idle(2);
        sofBeat();
        idle(1);

        $display("[TB] SOF coincident with commit");
        wr(2'd0, 16'd77);
        applyStimulus(1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b1);
        idle(3);
        sofBeat();
        idle(2);

        $display("[TB] frame counter wrap");
        for (int i = 0; i < 17; i++) sofBeat();
        idle(1);

        $display("[TB] reset while armed");
        wr(2'd0, 16'd50);
        wr(2'd1, 16'd900);
        commitReq();
        idle(3);
        doReset();
        idle(1);
        sofBeat();
        idle(2);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            wv   = ($urandom_range(0, 2) == 0);
            addr = 2'($urandom_range(0, 3));
            data = 16'($urandom_range(0, 65535));
            cm   = ($urandom_range(0, 7) == 0);
            tv   = ($urandom_range(0, 3) != 0);
            tu   = ($urandom_range(0, 5) == 0);
            applyStimulus(wv, addr, data, cm, tv, tu);
        end
        idle(2);

        #2;
        if (exp_q.size() != 0) checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hist_eq_param_ctrl.md
HIST_EQ_PARAM_CTRL -- requirements
Module: hist_eq_param_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 8, pixel/threshold width
- FCNT_WIDTH, 16, frame counter width
REQ-002 Ports SHALL be:
- i_sys_clk  in  1  clock
- i_sys_aresetn  in  1  reset
- cfg_wr_valid  in  1  config write request
- cfg_wr_ready  out  1  config write accepted
- cfg_wr_addr  in  2  register select
- cfg_wr_data  in  16  write data
- cfg_commit  in  1  single-cycle commit request
- mon_tvalid  in  1  monitored pixel-stream tvalid
- mon_tuser  in  1  monitored pixel-stream tuser (start of frame)
- contrast_threshold_param  out  DATA_WIDTH  active threshold
- upper_bound_param  out  10  active upper bound, 1/1024 units
- lower_bound_param  out  10  active lower bound, 1/1024 units
- thresholding_en  out  1  active mask enable
- cfg_pending  out  1  commit armed, awaiting frame start
- cfg_applied  out  1  one-cycle pulse, active set updated
- cfg_err  out  1  sticky, invalid commit rejected
- frame_cnt  out  FCNT_WIDTH  count of frame starts
REQ-003 Reset SHALL be i_sys_aresetn, asynchronous, active-low; clock SHALL be i_sys_clk.

Function
REQ-004 Shadow registers SHALL be written on cfg_wr_valid & cfg_wr_ready, using the low bits of cfg_wr_data:
- addr 0: contrast [DATA_WIDTH-1:0]
- addr 1: upper [9:0]
- addr 2: lower [9:0]
- addr 3: bit0 = thresholding_en; bit1 = 1 clears cfg_err (write-one-to-clear, not stored)
REQ-005 The FSM SHALL have states IDLE, CHECK and ARMED.
REQ-006 cfg_wr_ready SHALL equal (state==IDLE) & ~cfg_commit (combinational). In the commit cycle the commit wins and the write stalls.
REQ-007 IDLE -> CHECK SHALL occur on cfg_commit; cfg_commit outside IDLE SHALL be ignored.
REQ-008 In CHECK, the commit SHALL be valid iff shadow lower < shadow upper. Valid: CHECK -> ARMED. Invalid: cfg_err <= 1 and CHECK -> IDLE, with the active set unchanged.
REQ-009 ARMED -> IDLE SHALL occur on mon_tvalid & mon_tuser. On that same edge all active outputs SHALL load from the shadow registers and cfg_applied SHALL pulse 1 for the following cycle.
REQ-010 A frame start seen in IDLE or CHECK SHALL NOT apply the shadow set. A commit coinciding with a frame start therefore applies at the next frame start.
REQ-011 cfg_pending SHALL be 1 exactly while state==ARMED.
REQ-012 Active outputs SHALL change only per REQ-009, never mid-frame.
REQ-013 frame_cnt SHALL increment on every mon_tvalid & mon_tuser beat in any state, wrapping modulo 2^FCNT_WIDTH.
REQ-014 cfg_err SHALL set per REQ-008 and clear only per REQ-004. If set and clear occur in the same cycle, set SHALL win.
REQ-015 Outputs SHALL be registered, except cfg_wr_ready.

Reset
REQ-016 On reset, both shadow and active sets SHALL take these values:
- contrast = 128
- upper = 717
- lower = 205
- thresholding_en = 1
REQ-017 On reset, state SHALL be IDLE, and cfg_pending, cfg_applied, cfg_err and frame_cnt SHALL be 0.
REQ-018 Reset asserted while ARMED SHALL discard the pending commit; no cfg_applied pulse SHALL follow release.

Structure
REQ-019 A shared package hist_eq_pkg SHALL hold:
- the FSM state enum
- register address constants
- the reset default constants
REQ-020 The block SHALL be a single module with no sub-modules; the active outputs connect directly to the hist_eq datapath parameter inputs.

Verification
REQ-021 Reset defaults: release reset -> outputs 128/717/205/1, cfg_wr_ready=1, frame_cnt=0.
REQ-022 Frame-aligned apply:
- write upper=800, lower=100, commit -> cfg_pending=1 from 2 cycles later
- outputs unchanged mid-frame
- SOF beat -> outputs 800/100 one cycle later, cfg_applied pulses once
REQ-023 Invalid commit: write lower=900 (upper 717), commit -> cfg_err=1, cfg_pending stays 0, outputs unchanged. Then write addr 3 with data 0x3 -> cfg_err=0.
REQ-024 Write blocking: cfg_wr_valid held during a commit cycle and during ARMED -> cfg_wr_ready=0 throughout, shadow values unchanged, write completes after the apply.
REQ-025 SOF coincident with commit: no apply on that SOF; apply on the following SOF, which is frame_cnt+2 relative to the commit.
REQ-026 Counter wrap and reset: with FCNT_WIDTH=4, 17 SOF beats -> frame_cnt=1. Reset asserted while ARMED -> after release, no cfg_applied pulse and outputs at the REQ-016 defaults.
